// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller_pkg
// Purpose  : Shared encodings for the multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package mc_controller_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      CL_NOP   = 4'd0,
      CL_RTYPE = 4'd1,
      CL_IMM   = 4'd2,
      CL_LOAD  = 4'd3,
      CL_STORE = 4'd4,
      CL_BEQ   = 4'd5,
      CL_J     = 4'd6,
      CL_JAL   = 4'd7,
      CL_JR    = 4'd8
   } iclass_t;

   localparam logic [5:0] C_OP_RTYPE = 6'b000000;
   localparam logic [5:0] C_OP_ORI   = 6'b001101;
   localparam logic [5:0] C_OP_LUI   = 6'b001111;
   localparam logic [5:0] C_OP_LW    = 6'b100011;
   localparam logic [5:0] C_OP_SW    = 6'b101011;
   localparam logic [5:0] C_OP_BEQ   = 6'b000100;
   localparam logic [5:0] C_OP_J     = 6'b000010;
   localparam logic [5:0] C_OP_JAL   = 6'b000011;

   localparam logic [5:0] C_FN_ADDU  = 6'b100001;
   localparam logic [5:0] C_FN_SUBU  = 6'b100011;
   localparam logic [5:0] C_FN_OR    = 6'b100101;
   localparam logic [5:0] C_FN_JR    = 6'b001000;

   localparam logic [2:0] C_ALU_ADD  = 3'b000;
   localparam logic [2:0] C_ALU_SUB  = 3'b001;
   localparam logic [2:0] C_ALU_OR   = 3'b011;
   localparam logic [2:0] C_ALU_LUI  = 3'b100;

   localparam logic [1:0] C_PC_PLUS4  = 2'b00;
   localparam logic [1:0] C_PC_BRANCH = 2'b01;
   localparam logic [1:0] C_PC_JUMP   = 2'b10;
   localparam logic [1:0] C_PC_JR     = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Purpose  : Combinational op/func to instruction-class and ALU-code mapping.
// Revision : 1.0 - initial release
// ============================================================================
module mc_decode
   import mc_controller_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_func,
   output iclass_t    o_class,
   output logic [2:0] o_alu_ctrl
);

   // Anything not recognised falls through as NOP.
   always_comb begin
      o_class    = CL_NOP;
      o_alu_ctrl = C_ALU_ADD;
      case (i_op)
         C_OP_RTYPE: begin
            case (i_func)
               C_FN_ADDU: o_class = CL_RTYPE;
               C_FN_SUBU: begin
                  o_class    = CL_RTYPE;
                  o_alu_ctrl = C_ALU_SUB;
               end
               C_FN_OR: begin
                  o_class    = CL_RTYPE;
                  o_alu_ctrl = C_ALU_OR;
               end
               C_FN_JR: o_class = CL_JR;
               default: o_class = CL_NOP;
            endcase
         end
         C_OP_ORI: begin
            o_class    = CL_IMM;
            o_alu_ctrl = C_ALU_OR;
         end
         C_OP_LUI: begin
            o_class    = CL_IMM;
            o_alu_ctrl = C_ALU_LUI;
         end
         C_OP_LW:  o_class = CL_LOAD;
         C_OP_SW:  o_class = CL_STORE;
         C_OP_BEQ: begin
            o_class    = CL_BEQ;
            o_alu_ctrl = C_ALU_SUB;
         end
         C_OP_J:   o_class = CL_J;
         C_OP_JAL: o_class = CL_JAL;
         default:  o_class = CL_NOP;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller
   import mc_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       alu_src,
   output logic       reg_dst,
   output logic       sign,
   output logic       jal_save,
   output logic [2:0] alu_ctrl,
   output logic       instr_done
);

   state_t     r_state;
   iclass_t    r_class;
   logic [2:0] r_alu;
   iclass_t    w_dec_class;
   logic [2:0] w_dec_alu;

   mc_decode u_decode (
      .i_op       (op),
      .i_func     (func),
      .o_class    (w_dec_class),
      .o_alu_ctrl (w_dec_alu)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_class <= CL_NOP;
         r_alu   <= C_ALU_ADD;
      end else begin
         case (r_state)
            ST_FETCH: r_state <= ST_DECODE;
            ST_DECODE: begin
               r_class <= w_dec_class;
               r_alu   <= w_dec_alu;
               case (w_dec_class)
                  CL_J, CL_JR, CL_NOP: r_state <= ST_FETCH;
                  CL_JAL:              r_state <= ST_WB;
                  default:             r_state <= ST_EXEC;
               endcase
            end
            ST_EXEC: begin
               case (r_class)
                  CL_LOAD, CL_STORE: r_state <= ST_MEM;
                  CL_RTYPE, CL_IMM:  r_state <= ST_WB;
                  default:           r_state <= ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) begin
                  r_state <= (r_class == CL_STORE) ? ST_FETCH : ST_WB;
               end
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   // DECODE uses the live decode because the class is only captured at its end;
   // reset gates everything so a store cannot keep writing while reset is held.
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = C_PC_PLUS4;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      sign       = 1'b0;
      jal_save   = 1'b0;
      alu_ctrl   = C_ALU_ADD;
      instr_done = 1'b0;
      if (!reset) begin
         case (r_state)
            ST_FETCH: begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
            ST_DECODE: begin
               case (w_dec_class)
                  CL_J: begin
                     pc_write   = 1'b1;
                     pc_src     = C_PC_JUMP;
                     instr_done = 1'b1;
                  end
                  CL_JR: begin
                     pc_write   = 1'b1;
                     pc_src     = C_PC_JR;
                     instr_done = 1'b1;
                  end
                  CL_JAL: begin
                     pc_write = 1'b1;
                     pc_src   = C_PC_JUMP;
                  end
                  CL_NOP:  instr_done = 1'b1;
                  default: instr_done = 1'b0;
               endcase
            end
            ST_EXEC: begin
               case (r_class)
                  CL_RTYPE: alu_ctrl = r_alu;
                  CL_IMM: begin
                     alu_src  = 1'b1;
                     alu_ctrl = r_alu;
                  end
                  CL_LOAD, CL_STORE: begin
                     alu_src = 1'b1;
                     sign    = 1'b1;
                  end
                  CL_BEQ: begin
                     sign       = 1'b1;
                     alu_ctrl   = C_ALU_SUB;
                     pc_write   = zero;
                     pc_src     = C_PC_BRANCH;
                     instr_done = 1'b1;
                  end
                  default: alu_ctrl = C_ALU_ADD;
               endcase
            end
            ST_MEM: begin
               if (r_class == CL_STORE) begin
                  mem_write  = 1'b1;
                  instr_done = mem_ready;
               end
            end
            ST_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               reg_dst    = (r_class == CL_RTYPE);
               mem_to_reg = (r_class == CL_LOAD);
               jal_save   = (r_class == CL_JAL);
            end
            default: instr_done = 1'b0;
         endcase
      end
   end

endmodule
`default_nettype wire
